padded_fm_reader: RTL and testbench

Read-side counterpart to the padding writer: walks a zero-padded feature map already stored in the global buffer and streams it, window by window, to the convolution PE array. It generates buffer read addresses for every K×K window at stride 1 or 2, absorbs the buffer's 1-cycle read latency, and presents PE-byte words on a valid/ready stream with full backpressure.

---
 rtl/padded_fm_reader.sv | 201 ++++++++++++++++++++
 tb/tb_padded_fm_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/padded_fm_reader.sv
// Streams every KxK window of a zero-padded feature map out of the global buffer.
// Reads are credit-limited so the 2-entry output FIFO can never overflow under backpressure.
module padded_fm_reader #(
   parameter int PE        = 16,
   parameter int ADDR_STEP = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [15:0]     base_addr,
   input  logic [7:0]      IFM_C,
   input  logic [7:0]      IFM_W,
   input  logic            padding,
   input  logic [3:0]      K,
   input  logic            stride2,
   output logic            rd_en,
   output logic [15:0]     rd_addr,
   input  logic [PE*8-1:0] rd_data,
   output logic [PE*8-1:0] data_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            win_last,
   output logic            busy,
   output logic            done
);

   localparam int DW = PE * 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;

   // Valid/ready: a beat moves on any rising edge where out_valid and out_ready are both 1;
   // while out_valid is 1 and out_ready is 0, data_out and win_last are held unchanged.

   logic [8:0]  wp, ho, k9;
   logic [7:0]  cw_n;
   logic        degenerate;

   assign wp   = {1'b0, IFM_W} + (padding ? 9'd2 : 9'd0);
   assign k9   = {5'd0, K};
   assign cw_n = IFM_C / 8'(PE);

   always_comb begin
      ho = '0;
      if (wp >= k9) ho = ((wp - k9) >> stride2) + 9'd1;
   end

   assign degenerate = (cw_n == 8'd0) || (ho == 9'd0);

   // Loop counters always point at the next read to issue; they wrap back to zero
   // after the final read so IDLE can issue read 0 directly on start.
   logic [8:0] oy, ox, oy_nxt, ox_nxt;
   logic [3:0] ky, kx, ky_nxt, kx_nxt;
   logic [7:0] cw, cw_nxt;
   logic       cw_end, kx_end, ky_end, ox_end, oy_end, all_end, win_end;

   assign cw_end  = (cw == cw_n - 8'd1);
   assign kx_end  = (kx == K - 4'd1);
   assign ky_end  = (ky == K - 4'd1);
   assign ox_end  = (ox == ho - 9'd1);
   assign oy_end  = (oy == ho - 9'd1);
   assign win_end = cw_end && kx_end && ky_end;
   assign all_end = win_end && ox_end && oy_end;

   always_comb begin
      cw_nxt = cw;
      kx_nxt = kx;
      ky_nxt = ky;
      ox_nxt = ox;
      oy_nxt = oy;
      if (!cw_end) cw_nxt = cw + 8'd1;
      else begin
         cw_nxt = '0;
         if (!kx_end) kx_nxt = kx + 4'd1;
         else begin
            kx_nxt = '0;
            if (!ky_end) ky_nxt = ky + 4'd1;
            else begin
               ky_nxt = '0;
               if (!ox_end) ox_nxt = ox + 9'd1;
               else begin
                  ox_nxt = '0;
                  oy_nxt = oy_end ? 9'd0 : oy + 9'd1;
               end
            end
         end
      end
   end

   logic [15:0] pix_y, pix_x, pix_idx, word_idx, cur_addr;

   always_comb begin
      pix_y    = (stride2 ? {6'd0, oy, 1'b0} : {7'd0, oy}) + {12'd0, ky};
      pix_x    = (stride2 ? {6'd0, ox, 1'b0} : {7'd0, ox}) + {12'd0, kx};
      pix_idx  = pix_y * {7'd0, wp} + pix_x;
      word_idx = pix_idx * {8'd0, cw_n} + {8'd0, cw};
      cur_addr = base_addr + word_idx * 16'(ADDR_STEP);
   end

   logic       pend, pend_last, rd_last, pop, issue;
   logic [1:0] count, count_nxt;

   assign pop       = out_valid && out_ready;
   assign count_nxt = count + {1'b0, pend} - {1'b0, pop};
   // Buffered plus in-flight reads, including the new one, never exceed two.
   assign issue     = (state == RUN) && (({1'b0, count_nxt} + {2'b0, rd_en}) < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         oy      <= '0;
         ox      <= '0;
         ky      <= '0;
         kx      <= '0;
         cw      <= '0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         rd_last <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (degenerate) state <= DRAIN;
                  else begin
                     rd_en   <= 1'b1;
                     rd_addr <= cur_addr;
                     rd_last <= win_end;
                     oy      <= oy_nxt;
                     ox      <= ox_nxt;
                     ky      <= ky_nxt;
                     kx      <= kx_nxt;
                     cw      <= cw_nxt;
                     state   <= all_end ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  rd_en   <= 1'b1;
                  rd_addr <= cur_addr;
                  rd_last <= win_end;
                  oy      <= oy_nxt;
                  ox      <= ox_nxt;
                  ky      <= ky_nxt;
                  kx      <= kx_nxt;
                  cw      <= cw_nxt;
                  if (all_end) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!rd_en && !pend && (count_nxt == 2'd0)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [DW-1:0] fifo_data [2];
   logic [1:0]    fifo_last;
   logic          wr_ptr, rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend         <= 1'b0;
         pend_last    <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
      end else begin
         pend      <= rd_en;
         pend_last <= rd_last;
         if (pend) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_nxt;
      end
   end

   assign out_valid = (count != 2'd0);
   assign data_out  = fifo_data[rd_ptr];
   assign win_last  = fifo_last[rd_ptr] && out_valid;

endmodule

// File: tb/tb_padded_fm_reader.sv
// Bench for padded_fm_reader: a loop-nest reference model predicts the address and beat
// streams; a buffer model answers reads one cycle later.
module tb_padded_fm_reader;

   localparam int PE = 16;
   localparam int DW = PE * 8;

   logic          clk, rst_n, start;
   logic [15:0]   base_addr;
   logic [7:0]    ifm_c, ifm_w;
   logic          padding, stride2;
   logic [3:0]    k;
   logic          rd_en;
   logic [15:0]   rd_addr;
   logic [DW-1:0] rd_data, data_out;
   logic          out_valid, out_ready, win_last, busy, done;

   padded_fm_reader #(.PE(PE), .ADDR_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .IFM_C(ifm_c), .IFM_W(ifm_w), .padding(padding), .K(k), .stride2(stride2),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .win_last(win_last), .busy(busy), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] seed;

   function automatic logic [DW-1:0] mem_word(input logic [15:0] a);
      return {4{~a, a ^ seed}};
   endfunction

   always @(posedge clk) if (rd_en) rd_data <= mem_word(rd_addr);

   // scoreboard
   logic [DW:0]  exp_q[$];
   logic [15:0]  exp_addr_q[$];
   int           checks, errors;
   int           total, issued, accepted, done_cnt;
   bit           xfer_pending, prev_stall, stall_mode;
   logic [DW-1:0] prev_data;
   logic         prev_last;
   logic [15:0]  last_addr;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic build_model(input int c, input int w, input int pad, input int kk,
                              input int s2, input logic [15:0] base);
      int wp, cwn, s, ho;
      logic [15:0] a;
      wp  = w + 2 * pad;
      cwn = c / PE;
      s   = s2 ? 2 : 1;
      ho  = (wp < kk) ? 0 : (wp - kk) / s + 1;
      if (cwn == 0) ho = 0;
      exp_q.delete();
      exp_addr_q.delete();
      total = 0;
      for (int oy = 0; oy < ho; oy++)
         for (int ox = 0; ox < ho; ox++)
            for (int ky = 0; ky < kk; ky++)
               for (int kx = 0; kx < kk; kx++)
                  for (int cw = 0; cw < cwn; cw++) begin
                     a = 16'(int'(base) + (((oy * s + ky) * wp + ox * s + kx) * cwn + cw) * 4);
                     exp_addr_q.push_back(a);
                     exp_q.push_back({(ky == kk - 1 && kx == kk - 1 && cw == cwn - 1), mem_word(a)});
                     total++;
                  end
   endtask

   task automatic monitor();
      logic [DW:0] e;
      logic [15:0] a;
      if (done) begin
         done_cnt++;
         if (total > 0) chk("done_after_last", xfer_pending, 1);
         chk("done_beats_left", exp_q.size(), 0);
      end
      if (rd_en) begin
         issued++;
         if (exp_addr_q.size() == 0) chk("rd_extra", issued, total);
         else begin
            a = exp_addr_q.pop_front();
            chk("rd_addr", rd_addr, a);
         end
         chk("rd_credit", (issued - accepted) <= 2, 1);
         last_addr = rd_addr;
      end else chk("rd_addr_hold", rd_addr, last_addr);
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", data_out, prev_data);
         chk("stall_last", win_last, prev_last);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("beat_extra", accepted + 1, total);
         else begin
            e = exp_q.pop_front();
            chk("beat_data", data_out, e[DW-1:0]);
            chk("beat_last", win_last, e[DW]);
         end
         accepted++;
      end
      xfer_pending = out_valid && out_ready;
      prev_stall   = out_valid && !out_ready;
      prev_data    = data_out;
      prev_last    = win_last;
   endtask

   // driver: monitor at negedge, drive inputs 1 time unit after posedge
   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_data_out"}, data_out, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_win_last"}, win_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic run_pass(input int c, input int w, input int pad, input int kk, input int s2,
                           input logic [15:0] base, input bit stall, input int restart_at,
                           input int abort_at);
      int n, budget;
      ifm_c = 8'(c); ifm_w = 8'(w); padding = pad[0]; k = 4'(kk); stride2 = s2[0];
      base_addr = base;
      build_model(c, w, pad, kk, s2, base);
      issued = 0; accepted = 0; done_cnt = 0;
      xfer_pending = 0; prev_stall = 0;
      stall_mode = stall;
      budget = total * 4 + 20;
      n = 0;
      start = 1'b1;
      while (done_cnt == 0 && n < budget) begin
         cycle();
         n++;
         start = (n == restart_at);
         if (n == 1) begin
            chk("busy_on_start", busy, 1);
            chk("rd_en_on_start", rd_en, total > 0);
         end
         if (total == 0 && n == 1) chk("degen_done_t1", done, 0);
         if (total == 0 && n == 2) chk("degen_done_t2", done, 1);
         if (total > 0 && n == 2) chk("valid_t1", out_valid, 0);
         if (total > 0 && n == 3) chk("valid_t2", out_valid, 1);
         if (abort_at > 0 && accepted == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs("abort");
            @(posedge clk);
            #1;
            chk_reset_outputs("abort_hold");
            @(negedge clk);
            rst_n = 1'b1;
            last_addr = '0;
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 0);
            return;
         end
      end
      start = 1'b0;
      chk("done_seen", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      repeat (3) cycle();
      chk("done_once", done_cnt, 1);
      chk("beats_total", accepted, total);
      chk("reads_total", issued, total);
      chk("beats_left", exp_q.size(), 0);
   endtask

   initial begin
      checks = 0; errors = 0;
      seed = 16'($urandom);
      start = 0; base_addr = 0; ifm_c = 16; ifm_w = 2; padding = 1; k = 3; stride2 = 0;
      out_ready = 1; stall_mode = 0; last_addr = '0; total = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_pass(16, 2, 1, 3, 0, 16'h0000, 0, -1, 0);
      chk("case1_beats", accepted, 36);
      run_pass(32, 2, 1, 3, 1, 16'h0100, 0, -1, 0);
      chk("case2_beats", accepted, 18);
      run_pass(16, 2, 1, 3, 0, 16'h0000, 1, -1, 0);
      chk("case3_beats", accepted, 36);
      run_pass(16, 1, 0, 3, 0, 16'h0040, 0, -1, 0);
      chk("degen_beats", accepted, 0);
      run_pass(16, 2, 1, 3, 0, 16'h0000, 0, -1, 10);
      run_pass(16, 2, 1, 3, 0, 16'h0000, 0, -1, 0);
      chk("replay_beats", accepted, 36);
      run_pass(32, 3, 1, 2, 0, 16'hFFFC, 1, 6, 0);
      for (int i = 0; i < 8; i++)
         run_pass(16 * $urandom_range(1, 3), $urandom_range(1, 5), $urandom_range(0, 1),
                  $urandom_range(1, 4), $urandom_range(0, 1), 16'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(3, 12), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
